// File: rtl/scope_cmd_pkg.sv
// Shared constants and state encodings for the oscilloscope host command receiver.
package scope_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] CMD_TRIG   = 8'h01;
  localparam logic [7:0] CMD_DIV_HI = 8'h02;
  localparam logic [7:0] CMD_DIV_LO = 8'h03;
  localparam logic [7:0] CMD_RUN    = 8'h04;

  localparam logic [7:0]  TRIG_LEVEL_RST = 8'h80;
  localparam logic [15:0] SAMPLE_DIV_RST = 16'h0001;
  localparam logic [7:0]  DIV_HI_RST     = 8'h00;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    P_SYNC,
    P_CMD,
    P_ARG,
    P_CHK
  } parser_state_e;

  function automatic logic is_known_cmd(input logic [7:0] code);
    return (code == CMD_TRIG) || (code == CMD_DIV_HI) ||
           (code == CMD_DIV_LO) || (code == CMD_RUN);
  endfunction

  // The ADC sampler treats a divider of 0 as undefined, so it is never emitted.
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, mid-bit sampling FSM, framing check.
module uart_rx_byte
  import scope_cmd_pkg::*;
#(
  parameter int unsigned DELAY_FRAMES = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [12:0] HALF_BIT = 13'(DELAY_FRAMES / 2);
  localparam logic [12:0] FULL_BIT = 13'(DELAY_FRAMES);
  localparam logic [12:0] CNT_MAX  = '1;

  logic [1:0]  sync;
  logic        rxs;
  rx_state_e   state;
  logic [12:0] cnt;
  logic [12:0] cnt_inc;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  // Preset to idle-high so reset release does not look like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], uart_rx};
  end

  assign rxs     = sync[1];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 13'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            cnt   <= 13'd1;
          end
        end
        RX_START: begin
          if (cnt == HALF_BIT) begin
            if (!rxs) begin
              state   <= RX_DATA;
              cnt     <= 13'd1;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_BIT) begin
            shift <= {rxs, shift[7:1]};
            cnt   <= 13'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_BIT) begin
            if (rxs) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_BREAK;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        RX_BREAK: begin
          if (rxs) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scope_cmd_rx.sv
// Host command receiver: decodes A5/CMD/ARG/CHK packets into capture configuration registers.
module scope_cmd_rx
  import scope_cmd_pkg::*;
#(
  parameter int unsigned DELAY_FRAMES   = 234,
  parameter int unsigned TIMEOUT_FRAMES = 23400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [7:0]  trig_level,
  output logic [15:0] sample_div,
  output logic        run,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic        frame_err
);

  localparam logic [23:0] GAP_LIMIT = 24'(TIMEOUT_FRAMES);
  localparam logic [23:0] GAP_MAX   = '1;

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          rx_frame_err;
  parser_state_e state;
  logic [7:0]    cmd_reg;
  logic [7:0]    arg_reg;
  logic [7:0]    div_hi;
  logic [23:0]   gap;
  logic          pkt_ok;
  logic          pkt_err;

  uart_rx_byte #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (rx_frame_err)
  );

  // Already a registered one-cycle pulse from the receiver.
  assign frame_err = rx_frame_err;

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    pkt_ok  = 1'b0;
    pkt_err = 1'b0;
    if (state == P_CHK && byte_valid) begin
      if (byte_data == (cmd_reg ^ arg_reg) && is_known_cmd(cmd_reg)) pkt_ok  = 1'b1;
      else                                                           pkt_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= P_SYNC;
      cmd_reg    <= '0;
      arg_reg    <= '0;
      div_hi     <= DIV_HI_RST;
      gap        <= '0;
      trig_level <= TRIG_LEVEL_RST;
      sample_div <= SAMPLE_DIV_RST;
      run        <= 1'b0;
      cmd_ok     <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_ok  <= pkt_ok;
      cmd_err <= pkt_err;

      if (pkt_ok) begin
        case (cmd_reg)
          CMD_TRIG:   trig_level <= arg_reg;
          CMD_DIV_HI: div_hi     <= arg_reg;
          CMD_DIV_LO: sample_div <= clamp_div({div_hi, arg_reg});
          CMD_RUN:    run        <= arg_reg[0];
          default: ;
        endcase
      end

      if (byte_valid) begin
        gap <= '0;
        case (state)
          P_SYNC: if (byte_data == SYNC_BYTE) state <= P_CMD;
          P_CMD: begin
            cmd_reg <= byte_data;
            state   <= P_ARG;
          end
          P_ARG: begin
            arg_reg <= byte_data;
            state   <= P_CHK;
          end
          P_CHK:   state <= P_SYNC;
          default: state <= P_SYNC;
        endcase
      end else if (state != P_SYNC) begin
        // A broken frame or a stalled host abandons the partial packet without reporting it.
        if (rx_frame_err || gap >= GAP_LIMIT) begin
          state <= P_SYNC;
          gap   <= '0;
        end else if (gap != GAP_MAX) begin
          gap <= gap + 24'd1;
        end
      end else begin
        gap <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scope_cmd_rx.sv
// Randomized self-checking bench for scope_cmd_rx against a packet-level reference model.
module tb_scope_cmd_rx;

  localparam int D  = 16;
  localparam int TO = 1600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [7:0]  trig_level;
  logic [15:0] sample_div;
  logic        run;
  logic        cmd_ok;
  logic        cmd_err;
  logic        frame_err;

  always #5 clk = ~clk;

  scope_cmd_rx #(
    .DELAY_FRAMES  (D),
    .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .trig_level(trig_level),
    .sample_div(sample_div),
    .run       (run),
    .cmd_ok    (cmd_ok),
    .cmd_err   (cmd_err),
    .frame_err (frame_err)
  );

  int errors = 0;
  int checks = 0;

  // Observed pulse activity, counted in high cycles so a stretched pulse shows up.
  int n_ok = 0, n_err = 0, n_fe = 0, n_bv = 0, n_ovl = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_ok)    n_ok++;
      if (cmd_err)   n_err++;
      if (frame_err) n_fe++;
      if (dut.byte_valid) n_bv++;
      if ((cmd_ok && cmd_err) || (cmd_ok && frame_err) || (cmd_err && frame_err)) n_ovl++;
    end
  end

  // Reference model: byte stream grouped into packets.
  logic [7:0]  m_trig = 8'h80;
  logic [15:0] m_div = 16'h0001;
  logic [7:0]  m_div_hi = 8'h00;
  logic        m_run = 1'b0;
  int          e_ok = 0, e_err = 0, e_fe = 0;
  logic [7:0]  pend[$];

  task automatic model_reset();
    m_trig = 8'h80;
    m_div = 16'h0001;
    m_div_hi = 8'h00;
    m_run = 1'b0;
    pend.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0]  c, a, k;
    logic [15:0] d;
    if (pend.size() == 0 && b != 8'hA5) return;
    pend.push_back(b);
    if (pend.size() == 4) begin
      c = pend[1];
      a = pend[2];
      k = pend[3];
      pend.delete();
      if (k == (c ^ a) && c >= 8'h01 && c <= 8'h04) begin
        e_ok++;
        case (c)
          8'h01: m_trig = a;
          8'h02: m_div_hi = a;
          8'h03: begin
            d = {m_div_hi, a};
            m_div = (d == 16'd0) ? 16'd1 : d;
          end
          default: m_run = a[0];
        endcase
      end else begin
        e_err++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".trig"}, 32'(trig_level), 32'(m_trig));
    check({tag, ".div"},  32'(sample_div), 32'(m_div));
    check({tag, ".run"},  32'(run), 32'(m_run));
    check({tag, ".ok"},   n_ok, e_ok);
    check({tag, ".err"},  n_err, e_err);
    check({tag, ".fe"},   n_fe, e_fe);
    check({tag, ".ovl"},  n_ovl, 0);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    uart_rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (D) @(negedge clk);
    end
    uart_rx = stop;
    repeat (D) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_model(input logic [7:0] b, input int gap = 0);
    send_byte(b);
    model_byte(b);
    if (gap > 0) idle(gap);
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] c, input logic [7:0] a,
                          input logic [7:0] k, input int gap = 0);
    send_model(8'hA5, gap);
    send_model(c, gap);
    send_model(a, gap);
    send_model(k, 0);
    idle(4);
    check_state(tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bv0;
    logic [7:0] c, a, k, j;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(5);
    check_state("reset");

    send_pkt("trig40", 8'h01, 8'h40, 8'h41);
    send_pkt("divhi12", 8'h02, 8'h12, 8'h10);
    send_pkt("divlo34", 8'h03, 8'h34, 8'h37);
    send_pkt("divhi00", 8'h02, 8'h00, 8'h02);
    send_pkt("divclamp", 8'h03, 8'h00, 8'h03);
    send_pkt("run_badchk", 8'h04, 8'h01, 8'h04);
    send_pkt("run1", 8'h04, 8'h01, 8'h05);
    send_pkt("run_badchk2", 8'h04, 8'h00, 8'h05);
    send_pkt("unknown07", 8'h07, 8'h00, 8'h07);

    // Short low glitch must not start a byte.
    bv0 = n_bv;
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * D);
    check("glitch.bv", n_bv, bv0);
    check_state("glitch");

    // Framing error mid-packet drops the partial packet.
    send_model(8'hA5);
    send_model(8'h01);
    send_byte(8'h55, 1'b0);
    pend.delete();
    e_fe++;
    idle(2 * D);
    check_state("frame");
    send_pkt("after_frame", 8'h01, 8'h33, 8'h32);

    // Gap longer than the timeout abandons the packet.
    send_model(8'hA5);
    send_model(8'h01);
    idle(2 * TO);
    pend.delete();
    send_model(8'h20);
    send_model(8'h21);
    idle(4);
    check_state("timeout");

    // Gap well inside the timeout keeps the packet alive.
    send_model(8'hA5);
    send_model(8'h01);
    idle(TO / 2);
    send_model(8'h66);
    send_model(8'h67);
    idle(4);
    check_state("slow_ok");

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h00;
        send_model(j, int'($urandom_range(0, 20)));
      end
      c = ($urandom_range(0, 5) < 4) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(0, 255));
      a = 8'($urandom_range(0, 255));
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : (c ^ a);
      send_pkt($sformatf("rand%0d", n), c, a, k, int'($urandom_range(0, 30)));
    end

    // Back-to-back packets with no idle between stop and next start.
    send_model(8'hA5); send_model(8'h01); send_model(8'h5A); send_model(8'h5B);
    send_model(8'hA5); send_model(8'h04); send_model(8'h00); send_model(8'h04);
    idle(4);
    check_state("b2b");

    // Reset in the middle of the next packet's first byte.
    uart_rx = 1'b0;
    repeat (D + D / 2) @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    #1;
    model_reset();
    check_state("rst_mid");
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(5);
    check_state("after_rst");
    send_pkt("post_rst", 8'h01, 8'h11, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
